// File: rtl/uart_tx_buf_pkg.sv
// rtl/uart_tx_buf_pkg.sv - shared bus widths, UART register address and decode helper
// Contents:
//   MEM_BUS, MEM_ADDR_BUS  data/address widths of the memory-mapped bus
//   UART_ADDR              address whose writes push a byte into the TX buffer
//   is_uart_write()        decodes a bus write aimed at UART_ADDR
package uart_tx_buf_pkg;

   localparam int MEM_BUS      = 32;
   localparam int MEM_ADDR_BUS = 32;

   localparam logic [MEM_ADDR_BUS-1:0] UART_ADDR = 32'h1000_0000;

   function automatic logic is_uart_write(input logic we,
                                          input logic [MEM_ADDR_BUS-1:0] addr);
      return we && (addr == UART_ADDR);
   endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// rtl/uart_tx_buf_if.sv - bus write port feeding the UART TX buffer
// Signals:
//   we_i     write strobe
//   waddr_i  write address (MEM_ADDR_BUS bits)
//   wdata_i  write data (MEM_BUS bits, byte in [7:0])
// Modports: master drives the write, slave (uart_tx_buf) receives it.
interface uart_tx_buf_if;
   import uart_tx_buf_pkg::*;

   logic                    we_i;
   logic [MEM_ADDR_BUS-1:0] waddr_i;
   logic [MEM_BUS-1:0]      wdata_i;

   modport master (output we_i, output waddr_i, output wdata_i);
   modport slave  (input  we_i, input  waddr_i, input  wdata_i);

endinterface

// File: rtl/uart_tx_buf_sync_fifo.sv
// rtl/uart_tx_buf_sync_fifo.sv - synchronous show-ahead FIFO with registered flags
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push, din      write request and data (ignored when full unless popping)
//   pop, dout      read request (ignored when empty) and head data
//   full, empty    registered occupancy flags
//   count          registered occupancy, 0..DEPTH
module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;
   logic [AW:0]      count_n;

   // A push into a full FIFO is only legal when the head leaves in the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr];

   always_comb begin
      count_n = count;
      case ({do_push, do_pop})
         2'b10:   count_n = count + 1'b1;
         2'b01:   count_n = count - 1'b1;
         default: count_n = count;
      endcase
   end

   // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         count <= count_n;
         full  <= (count_n == (AW+1)'(DEPTH));
         empty <= (count_n == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered 8N1 UART transmitter fed by bus writes
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           slave write port; writes to UART_ADDR push wdata_i[7:0]
//   ovf_clr_i     clears the sticky overflow flag
//   tx_o          serial line, idle high
//   full_o, empty_o, count_o  registered FIFO status
//   tx_busy_o     high while a frame is being sent
//   ovf_o         sticky: a byte was dropped because the FIFO was full
module uart_tx_buf
   import uart_tx_buf_pkg::*;
#(
   parameter  int DEPTH    = 16,
   parameter  int BAUD_DIV = 434,
   localparam int CW       = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_buf_if.slave        bus,
   input  logic                ovf_clr_i,
   output logic                tx_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [CW-1:0]       count_o,
   output logic                tx_busy_o,
   output logic                ovf_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int            BW        = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   state_t        state;
   state_t        state_n;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic [7:0]    fifo_dout;
   logic          push_req;
   logic          pop;
   logic          bit_end;
   logic          unused_wdata;

   assign push_req     = is_uart_write(bus.we_i, bus.waddr_i);
   assign bit_end      = (baud_cnt == BAUD_LAST);
   assign unused_wdata = ^bus.wdata_i[MEM_BUS-1:8];

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .din   (bus.wdata_i[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full_o),
      .empty (empty_o),
      .count (count_o)
   );

   always_comb begin
      state_n   = state;
      pop       = 1'b0;
      tx_o      = 1'b1;
      tx_busy_o = (state != IDLE);
      case (state)
         IDLE: begin
            if (!empty_o) begin
               pop     = 1'b1;
               state_n = START;
            end
         end
         START: begin
            tx_o = 1'b0;
            if (bit_end) state_n = DATA;
         end
         DATA: begin
            tx_o = shift[0];
            if (bit_end && (bit_idx == 3'd7)) state_n = STOP;
         end
         STOP: begin
            if (bit_end) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // The shift register is loaded only on the pop edge, so later pushes
   // cannot disturb the byte currently on the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state <= state_n;
         if (pop) begin
            shift    <= fifo_dout;
            baud_cnt <= '0;
            bit_idx  <= '0;
         end else if (state != IDLE) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            if ((state == DATA) && bit_end) begin
               shift   <= shift >> 1;
               bit_idx <= bit_idx + 1'b1;
            end
         end
      end
   end

   // A drop in the same cycle as a clear wins, so no overflow is ever lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_o <= 1'b0;
      end else if (push_req && full_o && !pop) begin
         ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
         ovf_o <= 1'b0;
      end
   end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter BAUD_DIV, default 434, meaning clocks per UART bit (115200 baud at 50 MHz; at least 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  one clock; reset is synchronous and active-high.
REQ-005 we_i  input  1  bus write strobe from rib.
REQ-006 waddr_i  input  32  bus write address (MemAddrBus).
REQ-007 wdata_i  input  32  bus write data (MemBus); only bits [7:0] used.
REQ-008 tx_o  output  1  serial line, 8N1, idle high.
REQ-009 full_o  output  1  FIFO holds DEPTH bytes.
REQ-010 empty_o  output  1  FIFO holds 0 bytes.
REQ-011 count_o  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-012 tx_busy_o  output  1  high whenever serializer state is not IDLE.
REQ-013 ovf_o  output  1  sticky overflow flag.
REQ-014 ovf_clr_i  input  1  clears ovf_o.

Function
REQ-015 Push condition: we_i=1 and waddr_i==UART_ADDR; wdata_i[7:0] SHALL be written at tail in the same edge.
REQ-016 Writes to any other address SHALL be ignored with no state change.
REQ-017 Push while full with no same-cycle pop SHALL drop the byte, leave the FIFO unchanged, and set ovf_o on the next edge.
REQ-018 Push while full in a cycle where the serializer pops SHALL be accepted; count_o stays DEPTH and ovf_o is not set.
REQ-019 Push and pop in the same cycle on a non-full FIFO SHALL leave count_o unchanged and preserve byte order.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH or drop below 0.
REQ-021 ovf_clr_i=1 SHALL clear ovf_o; a simultaneous overflow event SHALL take priority, leaving ovf_o=1.
REQ-022 full_o, empty_o and count_o SHALL be registered, reflecting state after the last edge.
REQ-023 Serializer FSM states: IDLE, START, DATA, STOP.
REQ-024 IDLE with empty_o=0: pop head byte into shift register, reset baud counter, go to START.
REQ-025 START: tx_o=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
REQ-026 DATA: tx_o=shift[0] for BAUD_DIV cycles per bit, LSB first; shift right after each bit; after bit 7 go to STOP.
REQ-027 STOP: tx_o=1 for BAUD_DIV cycles, then go to IDLE.
REQ-028 Frame length SHALL be exactly 10*BAUD_DIV cycles, with at least one IDLE cycle between frames.
REQ-029 In IDLE, tx_o SHALL be 1.
REQ-030 Baud counter SHALL count 0..BAUD_DIV-1 and wrap; a bit boundary occurs at count BAUD_DIV-1.
REQ-031 A pop SHALL occur only in IDLE; the byte in flight is never affected by later pushes.

Reset
REQ-032 rst=1 at an edge SHALL set: state=IDLE, tx_o=1, FIFO empty (empty_o=1, full_o=0, count_o=0), tx_busy_o=0, ovf_o=0, baud counter=0.
REQ-033 Reset mid-frame SHALL abort the frame; tx_o=1 from the next edge; buffered bytes are discarded.
REQ-034 rst SHALL have priority over all pushes, pops and ovf_clr_i in the same cycle.

Structure
REQ-035 UART_ADDR, MemBus and MemAddrBus SHALL come from the shared defines.v; no local redefinition.
REQ-036 FSM state encodings SHALL be local parameters of this module.
REQ-037 The FIFO SHALL be a sub-module sync_fifo (parameter DEPTH, width 8, push/pop/full/empty/count), reusable elsewhere.

Verification (bench uses BAUD_DIV=4, DEPTH=4)
REQ-038 Single write 0x32 to UART_ADDR -> tx_o pattern 0,0,1,0,0,1,1,0,0,1 (start, LSB-first data, stop), each held 4 cycles; 40-cycle frame; tx_busy_o high throughout.
REQ-039 Ten back-to-back writes of ASCII "2023310655" (0x32,0x30,0x32,0x33,0x33,0x31,0x30,0x36,0x35,0x35), one per cycle -> serial bytes appear in that order; ovf_o=1 once pushes exceed FIFO space; dropped bytes are absent from the stream.
REQ-040 Fill to 4 entries while a frame is in flight, then write 0x41 in the IDLE pop cycle -> accepted, count_o remains 4, ovf_o remains 0.
REQ-041 Write 0x55 to UART_ADDR+4 -> no push; empty_o stays 1; tx_o stays 1.
REQ-042 Assert rst at cycle 15 of a frame -> next edge gives tx_o=1, count_o=0, tx_busy_o=0, ovf_o=0.
REQ-043 Overflow and ovf_clr_i in the same cycle -> ovf_o=1; ovf_clr_i alone on a later cycle -> ovf_o=0.
